// File: rtl/adder_result_acc.sv
// Burst accumulator for the 4-bit adder result stream: sums BURST_LEN samples of {carry,sum}
// and presents the total with a sticky overflow flag on a held valid/ready output.
module adder_result_acc #(
  parameter int BURST_LEN = 16,
  parameter int ACC_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_data,
  input  logic             in_cy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clr,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             dbg_state
);

  localparam int CNT_W = (BURST_LEN > 2) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] out_acc_q, out_acc_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_valid_q, out_valid_d;

  logic             fire;
  logic [ACC_W:0]   sum;

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
  // The producer holds data stable while valid is high and ready is low; in_ready depends
  // only on state, and out_valid/out_acc/out_ovf stay put until out_ready takes them.
  assign in_ready  = (state_q == ACCUM);
  assign fire      = in_valid & in_ready;
  assign sum       = {1'b0, acc_q} + {{(ACC_W - 4){1'b0}}, in_cy, in_data};

  assign out_acc   = out_acc_q;
  assign out_ovf   = out_ovf_q;
  assign out_valid = out_valid_q;
  assign busy      = (cnt_q != '0) | (state_q == HOLD);
  assign dbg_state = state_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_acc_d   = out_acc_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;

    if (clr) begin
      // Abort discards any sample in this cycle and any pending result; last output kept.
      state_d     = ACCUM;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (fire) begin
            if (cnt_q == CNT_LAST) begin
              out_acc_d   = sum[ACC_W-1:0];
              out_ovf_d   = ovf_q | sum[ACC_W];
              out_valid_d = 1'b1;
              state_d     = HOLD;
              acc_d       = '0;
              cnt_d       = '0;
              ovf_d       = 1'b0;
            end else begin
              acc_d = sum[ACC_W-1:0];
              ovf_d = ovf_q | sum[ACC_W];
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ACCUM;
          end
        end
        default: begin
          state_d = ACCUM;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_acc_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_acc_q   <= out_acc_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
